rgb2hsv: RTL

RGB2HSV -- requirements
Module: rgb2hsv

---
 rtl/rgb2hsv.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/rgb2hsv.sv
// rgb2hsv: iterative 8-bit RGB to HSV converter.
// One conversion at a time: IDLE -> CALC -> DIV_S (16) -> DIV_H (16) -> DONE -> IDLE.
// A single restoring divider is time-shared between the saturation and hue
// divisions, so one result is produced every 35 cycles.
// Hue is scaled so a full circle spans 0..255 (red 0, green 85, blue 171).
module rgb2hsv (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] h,
    output logic [7:0] s,
    output logic [7:0] v,
    output logic       out_valid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        DIV_S = 3'd2,
        DIV_H = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] DOM_R = 2'd0;
    localparam logic [1:0] DOM_G = 2'd1;
    localparam logic [1:0] DOM_B = 2'd2;

    localparam logic [7:0] BASE_R = 8'd0;
    localparam logic [7:0] BASE_G = 8'd85;
    localparam logic [7:0] BASE_B = 8'd171;

    state_t      r_state;
    logic [3:0]  r_cnt;

    // pixel captured on accept; later input changes cannot disturb it
    logic [7:0]  r_red;
    logic [7:0]  r_grn;
    logic [7:0]  r_blu;

    // per-pixel quantities registered in CALC
    logic [7:0]  r_max;
    logic [7:0]  r_delta;
    logic [7:0]  r_base;
    logic        r_neg;
    logic [7:0]  r_absx;
    logic [7:0]  r_s_res;

    // shared restoring divider: r_dvd shifts the dividend out and the quotient in
    logic [15:0] r_dvd;
    logic [7:0]  r_rem;
    logic [7:0]  r_dsr;

    // registered outputs
    logic [7:0]  r_h;
    logic [7:0]  r_s;
    logic [7:0]  r_v;
    logic        r_out_valid;
    logic        r_in_ready;

    logic [1:0]        w_dom;
    logic [7:0]        w_max;
    logic [7:0]        w_min;
    logic [7:0]        w_delta;
    logic signed [8:0] w_x;
    logic              w_neg;
    logic [7:0]        w_absx;
    logic [7:0]        w_base;
    logic [15:0]       w_dvd_s;
    logic [15:0]       w_dvd_h;

    logic [8:0]        w_rem_sh;
    logic              w_ge;
    logic [7:0]        w_rem_nx;
    logic [15:0]       w_quo_nx;
    logic [7:0]        w_q;
    logic [7:0]        w_h;
    logic [7:0]        w_s;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign h         = r_h;
    assign s         = r_s;
    assign v         = r_v;

    // max/min/delta, dominant channel (ties favour r, then g) and hue numerator
    always_comb begin
        w_dom  = DOM_B;
        w_max  = r_blu;
        w_x    = $signed({1'b0, r_red}) - $signed({1'b0, r_grn});
        w_base = BASE_B;
        if (r_red >= r_grn && r_red >= r_blu) begin
            w_dom  = DOM_R;
            w_max  = r_red;
            w_x    = $signed({1'b0, r_grn}) - $signed({1'b0, r_blu});
            w_base = BASE_R;
        end else if (r_grn >= r_blu) begin
            w_dom  = DOM_G;
            w_max  = r_grn;
            w_x    = $signed({1'b0, r_blu}) - $signed({1'b0, r_red});
            w_base = BASE_G;
        end

        w_min = r_red;
        if (r_grn < w_min) w_min = r_grn;
        if (r_blu < w_min) w_min = r_blu;

        w_delta = w_max - w_min;
        w_neg   = w_x[8];
        // |x| is at most 255, so the low 8 bits of the two's complement negation suffice
        w_absx  = w_neg ? 8'(9'd0 - w_x) : w_x[7:0];
        w_dvd_s = 16'(w_delta) * 16'd255;
        w_dvd_h = 16'(r_absx) * 16'd43;
    end

    // one restoring-division step plus final result selection with zero-divisor forcing
    always_comb begin
        w_rem_sh = {r_rem, r_dvd[15]};
        w_ge     = (w_rem_sh >= {1'b0, r_dsr});
        w_rem_nx = w_ge ? 8'(w_rem_sh - {1'b0, r_dsr}) : w_rem_sh[7:0];
        w_quo_nx = {r_dvd[14:0], w_ge};
        // both quotients are bounded below 256, so the low byte is exact
        w_q      = w_quo_nx[7:0];
        w_s      = (r_max == 8'd0) ? 8'd0 : w_q;
        if (r_delta == 8'd0)
            w_h = 8'd0;
        else if (r_neg)
            w_h = r_base - w_q;
        else
            w_h = r_base + w_q;
    end

    // control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_red       <= 8'd0;
            r_grn       <= 8'd0;
            r_blu       <= 8'd0;
            r_max       <= 8'd0;
            r_delta     <= 8'd0;
            r_base      <= 8'd0;
            r_neg       <= 1'b0;
            r_absx      <= 8'd0;
            r_s_res     <= 8'd0;
            r_dvd       <= 16'd0;
            r_rem       <= 8'd0;
            r_dsr       <= 8'd0;
            r_h         <= 8'd0;
            r_s         <= 8'd0;
            r_v         <= 8'd0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_red      <= r;
                        r_grn      <= g;
                        r_blu      <= b;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_max   <= w_max;
                    r_delta <= w_delta;
                    r_base  <= w_base;
                    r_neg   <= w_neg;
                    r_absx  <= w_absx;
                    // saturation division: 255*delta / max
                    r_dvd   <= w_dvd_s;
                    r_rem   <= 8'd0;
                    r_dsr   <= w_max;
                    r_cnt   <= 4'd0;
                    r_state <= DIV_S;
                end
                DIV_S: begin
                    r_dvd <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_s_res <= w_s;
                        // hue division: 43*|x| / delta
                        r_dvd   <= w_dvd_h;
                        r_rem   <= 8'd0;
                        r_dsr   <= r_delta;
                        r_state <= DIV_H;
                    end
                end
                DIV_H: begin
                    r_dvd <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_h     <= w_h;
                        r_s     <= r_s_res;
                        r_v     <= r_max;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    // the dominant-channel code only steers the muxes above
    logic w_dom_unused;
    assign w_dom_unused = ^w_dom;

endmodule
